// File: rtl/mpsk_mod_gen.sv
// M-PSK modulator: a phase-continuous NCO addresses an external registered sine ROM,
// and each symbol rotates the ROM address by a fixed phase offset.
module mpsk_mod_gen #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int SPS_W  = 16,
  parameter bit GRAY   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ACC_W-1:0]  freq_word,
  input  logic [SPS_W-1:0]  sym_period,
  input  logic [1:0]        mode,
  input  logic [2:0]        sym_data,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] mod_data,
  output logic              mod_valid,
  output logic              underrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef enum logic [1:0] {
    M_BPSK  = 2'd0,
    M_QPSK  = 2'd1,
    M_8PSK  = 2'd2,
    M_QPSK2 = 2'd3
  } mode_t;

  state_t             state;
  mode_t              mode_q;
  logic [2:0]         sym_q;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   fw_q;
  logic [SPS_W-1:0]   sym_cnt;
  logic [SPS_W-1:0]   period_m1;
  logic [ADDR_W-1:0]  offset;
  logic               addr_vld;
  logic               vld_d1;
  logic               ready_en;

  // Only the bits the mode actually uses are decoded, so stray upper bits never
  // leak into the phase (Gray decode included).
  function automatic logic [ADDR_W-1:0] phase_offset(input logic [2:0] s, input mode_t m);
    logic [2:0]        b;
    logic [ADDR_W-1:0] off;
    b   = 3'b000;
    off = '0;
    case (m)
      M_BPSK: begin
        off = ADDR_W'(s[0]) << (ADDR_W - 1);
      end
      M_8PSK: begin
        b   = GRAY ? {s[2], s[2] ^ s[1], s[2] ^ s[1] ^ s[0]} : s;
        off = ADDR_W'(b) << (ADDR_W - 3);
      end
      default: begin
        b[1:0] = GRAY ? {s[1], s[1] ^ s[0]} : s[1:0];
        off    = ADDR_W'(b[1:0]) << (ADDR_W - 2);
      end
    endcase
    return off;
  endfunction

  assign period_m1 = (sym_period == '0) ? '0 : sym_period - SPS_W'(1);
  assign offset    = phase_offset(sym_q, mode_q);

  // ready_en keeps sym_ready low while reset is held and for the release edge.
  assign sym_ready = ready_en && ((state == IDLE) || (sym_cnt == '0));

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode_q    <= M_BPSK;
      sym_q     <= '0;
      acc       <= '0;
      fw_q      <= '0;
      sym_cnt   <= '0;
      rom_addr  <= '0;
      addr_vld  <= 1'b0;
      vld_d1    <= 1'b0;
      mod_data  <= '0;
      mod_valid <= 1'b0;
      underrun  <= 1'b0;
      ready_en  <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      underrun  <= 1'b0;
      vld_d1    <= addr_vld;
      mod_valid <= vld_d1;
      mod_data  <= vld_d1 ? rom_q : '0;

      case (state)
        IDLE: begin
          acc      <= '0;
          rom_addr <= '0;
          addr_vld <= 1'b0;
          if (sym_valid && sym_ready) begin
            sym_q   <= sym_data;
            mode_q  <= mode_t'(mode);
            fw_q    <= freq_word;
            sym_cnt <= period_m1;
            state   <= ACTIVE;
          end
        end

        ACTIVE: begin
          acc      <= acc + fw_q;
          rom_addr <= acc[ACC_W-1 -: ADDR_W] + offset;
          addr_vld <= 1'b1;
          if (sym_cnt != '0) begin
            sym_cnt <= sym_cnt - SPS_W'(1);
          end else if (sym_valid) begin
            // Reload without touching acc keeps the carrier phase-continuous.
            sym_q   <= sym_data;
            mode_q  <= mode_t'(mode);
            sym_cnt <= period_m1;
          end else begin
            // The starving edge still issues the symbol's final sample; IDLE then
            // clears the address path on the following edge.
            state    <= IDLE;
            underrun <= 1'b1;
            acc      <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
